// File: rtl/multicycle_decoder.sv
// multicycle_decoder: fetches i281 instructions and sequences their phases for the opcode register
module multicycle_decoder #(
  parameter int INSTR_WIDTH = 16,
  parameter int FETCH_TIMEOUT = 15,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   imem_valid,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  output logic                   imem_req,
  output logic [7:0]             output_to_multicycle_opcode,
  output logic                   phase_valid,
  output logic                   instr_done,
  output logic                   fetch_error,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] instr_count
);
  localparam int TW = $clog2(FETCH_TIMEOUT + 1);
  // Encodings double as the phase code; IDLE uses an otherwise undriven code
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, IDLE = 3'd7} state_t;
  state_t state, nxt;
  logic [3:0] op;
  logic [TW-1:0] tcnt;
  logic last, timeout, alu, short_op, mem_last;
  logic unused;
  assign unused = ^imem_instr[INSTR_WIDTH-5:0];
  assign alu = op inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hC};
  assign short_op = op inside {4'hD, 4'hE, 4'hF};
  assign mem_last = op inside {4'h1, 4'hA, 4'hB};
  always_comb begin
    nxt = state;
    last = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: nxt = (run && !fetch_error) ? FETCH : IDLE;
      FETCH: begin
        timeout = !imem_valid && tcnt == TW'(FETCH_TIMEOUT - 1);
        nxt = imem_valid ? DECODE : timeout ? IDLE : FETCH;
      end
      DECODE: begin
        last = op == 4'h0;
        nxt = EXEC;
      end
      EXEC: begin
        last = short_op;
        nxt = alu ? WB : MEM;
      end
      MEM: begin
        last = mem_last;
        nxt = WB;
      end
      WB: last = 1'b1;
      default: nxt = IDLE;
    endcase
    if (last) nxt = run ? FETCH : IDLE;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      op <= '0;
      tcnt <= '0;
      fetch_error <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= nxt;
      if (state == FETCH && imem_valid) op <= imem_instr[INSTR_WIDTH-1 -: 4];
      tcnt <= (state == FETCH && !imem_valid && !timeout) ? tcnt + 1'b1 : '0;
      fetch_error <= fetch_error | timeout;
      if (last) instr_count <= instr_count + 1'b1;
    end
  end
  assign imem_req = state == FETCH;
  assign phase_valid = state inside {DECODE, EXEC, MEM, WB};
  assign output_to_multicycle_opcode = phase_valid ? {op, state, last} : 8'h00;
  assign instr_done = last;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_multicycle_decoder.sv
// tb_multicycle_decoder: directed and randomized checks against a phase-table model
module tb_multicycle_decoder;
  logic clock = 1'b0, reset = 1'b0, run = 1'b0, imem_valid = 1'b0;
  logic [15:0] imem_instr = '0;
  logic imem_req, phase_valid, instr_done, fetch_error, busy;
  logic [7:0] word;
  logic [15:0] instr_count;
  logic w_req, w_pv, w_done, w_err, w_busy;
  logic [7:0] w_word;
  logic [3:0] w_count;
  int compared = 0, mismatched = 0;
  logic [15:0] mc = '0;
  always #5 clock = ~clock;
  multicycle_decoder dut (
    .clock(clock), .reset(reset), .run(run), .imem_valid(imem_valid), .imem_instr(imem_instr),
    .imem_req(imem_req), .output_to_multicycle_opcode(word), .phase_valid(phase_valid),
    .instr_done(instr_done), .fetch_error(fetch_error), .busy(busy), .instr_count(instr_count)
  );
  multicycle_decoder #(.COUNT_WIDTH(4)) dut_w (
    .clock(clock), .reset(reset), .run(run), .imem_valid(imem_valid), .imem_instr(imem_instr),
    .imem_req(w_req), .output_to_multicycle_opcode(w_word), .phase_valid(w_pv),
    .instr_done(w_done), .fetch_error(w_err), .busy(w_busy), .instr_count(w_count)
  );
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  // Entered while in FETCH; leaves the DUT in FETCH (run_after=1) or IDLE
  task automatic run_instr(input logic [15:0] ins, input int dly, input bit run_after);
    logic [3:0] op;
    int ph[$];
    bit last;
    op = ins[15:12];
    ph.push_back(1);
    if (op != 4'h0) ph.push_back(2);
    if (op inside {4'h1, 4'h8, 4'h9, 4'hA, 4'hB}) ph.push_back(3);
    if (op inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hC, 4'h8, 4'h9}) ph.push_back(4);
    for (int i = 0; i < dly; i++) begin
      chk("fetch_wait_req", imem_req, 1);
      chk("fetch_wait_pv", phase_valid, 0);
      imem_valid = 1'b0;
      imem_instr = 16'($urandom);
      step();
    end
    chk("fetch_req", imem_req, 1);
    chk("fetch_pv", phase_valid, 0);
    chk("fetch_busy", busy, 1);
    imem_valid = 1'b1;
    imem_instr = ins;
    step();
    foreach (ph[k]) begin
      last = k == ph.size() - 1;
      imem_valid = 1'($urandom);
      imem_instr = 16'($urandom);
      chk("word", word, {op, 3'(ph[k]), last});
      chk("pv", phase_valid, 1);
      chk("done", instr_done, last);
      chk("busy", busy, 1);
      run = last ? run_after : 1'($urandom);
      step();
      if (last) mc++;
    end
    imem_valid = 1'b0;
    chk("count", instr_count, mc);
    chk("count_w", w_count, mc[3:0]);
    chk("req_after", imem_req, run_after);
    chk("busy_after", busy, run_after);
  endtask
  initial begin
    logic [15:0] ins;
    bit ra;
    int dly;
    repeat (2) step();
    chk("rst_word", word, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_pv", phase_valid, 0);
    chk("rst_done", instr_done, 0);
    chk("rst_err", fetch_error, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", instr_count, 0);
    reset = 1'b1;
    step();
    chk("idle_busy", busy, 0);
    run = 1'b1;
    step();
    run_instr(16'h4123, 0, 1);
    run_instr(16'h8204, 0, 0);
    chk("load_idle_word", word, 0);
    chk("load_count", instr_count, 2);
    run = 1'b1;
    step();
    repeat (3) run_instr(16'h0000, 0, 1);
    for (int n = 0; n < 40; n++) begin
      ins = 16'($urandom);
      ra = (n == 39) ? 1'b0 : 1'($urandom);
      dly = (n % 10 == 5) ? 14 : $urandom_range(0, 3);
      run_instr(ins, dly, ra);
      if (!ra) begin
        repeat ($urandom_range(0, 2)) begin
          run = 1'b0;
          imem_valid = 1'($urandom);
          step();
          chk("idle_busy_r", busy, 0);
          chk("idle_word_r", word, 0);
        end
        imem_valid = 1'b0;
        if (n != 39) begin
          run = 1'b1;
          step();
        end
      end
    end
    run = 1'b1;
    step();
    for (int k = 0; k < 15; k++) begin
      chk("to_req", imem_req, 1);
      chk("to_err", fetch_error, 0);
      imem_valid = 1'b0;
      step();
    end
    chk("to_err_set", fetch_error, 1);
    chk("to_busy", busy, 0);
    chk("to_req_off", imem_req, 0);
    imem_valid = 1'b1;
    repeat (3) step();
    chk("to_blocked_busy", busy, 0);
    chk("to_blocked_req", imem_req, 0);
    chk("to_err_w", w_err, 1);
    imem_valid = 1'b0;
    reset = 1'b0;
    step();
    mc = '0;
    chk("rst2_err", fetch_error, 0);
    chk("rst2_count", instr_count, 0);
    reset = 1'b1;
    run = 1'b1;
    step();
    chk("st_req", imem_req, 1);
    imem_valid = 1'b1;
    imem_instr = 16'hA3FF;
    step();
    imem_valid = 1'b0;
    chk("st_dec", word, 8'hA2);
    step();
    chk("st_exec", word, 8'hA4);
    step();
    chk("st_mem", word, 8'hA7);
    chk("st_mem_done", instr_done, 1);
    reset = 1'b0;
    step();
    chk("st_rst_word", word, 0);
    chk("st_rst_done", instr_done, 0);
    chk("st_rst_req", imem_req, 0);
    chk("st_rst_busy", busy, 0);
    chk("st_rst_count", instr_count, mc);
    reset = 1'b1;
    run = 1'b0;
    step();
    chk("st_idle", busy, 0);
    run = 1'b1;
    step();
    for (int n = 0; n < 17; n++) run_instr(16'($urandom_range(0, 4095)), 0, n != 16);
    chk("wrap_count_w", w_count, 4'd1);
    chk("wrap_err_w", w_err, 0);
    chk("wrap_count", instr_count, 17);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
